// File: rtl/vector_mem_sequencer.sv
// Vector load/store sequencer: splits one vector memory op into LANES scalar
// accesses at base + k*stride and assembles load lanes into vec_rdata.
module vector_mem_sequencer #(
  parameter int LANES = 4,
  parameter int DW    = 8,
  parameter int AW    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  load,
  input  logic                  abort,
  input  logic [AW-1:0]         base_addr,
  input  logic [AW-1:0]         stride,
  input  logic [LANES*DW-1:0]   vec_wdata,
  input  logic [DW-1:0]         mem_rdata,
  output logic [AW-1:0]         mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [DW-1:0]         mem_wdata,
  output logic [LANES*DW-1:0]   vec_rdata,
  output logic                  vreg_we,
  output logic                  stall,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(LANES);
  localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       lane_q, lane_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [AW-1:0]       stride_q, stride_d;
  logic [LANES*DW-1:0] wdata_q, wdata_d;
  logic [LANES*DW-1:0] rdata_q;
  logic                load_q, load_d;
  logic                cap_vld_q, cap_vld_d;
  logic [CW-1:0]       cap_lane_q, cap_lane_d;
  logic                accept;

  assign accept = ((state_q == IDLE) || (state_q == FIN)) && start && !abort;

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    addr_d     = addr_q;
    stride_d   = stride_q;
    wdata_d    = wdata_q;
    load_d     = load_q;
    // Read data returns one cycle after the strobe, so remember which lane to fill.
    cap_vld_d  = (state_q == RUN) && load_q && !abort;
    cap_lane_d = lane_q;

    case (state_q)
      IDLE:  if (accept) state_d = RUN;
      RUN: begin
        if (lane_q == LAST_LANE) begin
          state_d = load_q ? DRAIN : FIN;
        end else begin
          lane_d = lane_q + CW'(1);
          addr_d = addr_q + stride_q;
        end
      end
      DRAIN: state_d = FIN;
      FIN:   state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase

    if (abort) state_d = IDLE;

    if (accept) begin
      lane_d   = '0;
      addr_d   = base_addr;
      stride_d = stride;
      wdata_d  = vec_wdata;
      load_d   = load;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      addr_q     <= '0;
      stride_q   <= '0;
      wdata_q    <= '0;
      load_q     <= 1'b0;
      cap_vld_q  <= 1'b0;
      cap_lane_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      addr_q     <= addr_d;
      stride_q   <= stride_d;
      wdata_q    <= wdata_d;
      load_q     <= load_d;
      cap_vld_q  <= cap_vld_d;
      cap_lane_q <= cap_lane_d;
      // Capture is not gated by abort: data for an already-issued lane is valid.
      if (cap_vld_q) rdata_q[cap_lane_q*DW +: DW] <= mem_rdata;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    vreg_we   = 1'b0;
    done      = 1'b0;
    stall     = 1'b0;
    case (state_q)
      RUN: begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q[lane_q*DW +: DW];
        mem_re    = load_q && !abort;
        mem_we    = !load_q && !abort;
        stall     = 1'b1;
      end
      DRAIN: stall = 1'b1;
      FIN: begin
        done    = !abort;
        vreg_we = load_q && !abort;
        stall   = start && !abort;
      end
      default: stall = start && !abort;
    endcase
    // State is already IDLE under reset, but start could still raise stall.
    if (!rst) stall = 1'b0;
  end

  assign busy      = (state_q != IDLE);
  assign vec_rdata = rdata_q;

endmodule

// File: doc/vector_mem_sequencer.md
VECTOR_MEM_SEQUENCER -- requirements
Module: vector_mem_sequencer

Interface
REQ-001 SHALL have parameter LANES, default 4, vector lane count; power of two, >=2.
REQ-002 SHALL have parameter DW, default 8, lane data width in bits.
REQ-003 SHALL have parameter AW, default 32, memory address width in bits.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  vector memory op request from decode (VectorOp with MemRead or MemWrite).
REQ-007 SHALL have port load  input  1  1 = vector load, 0 = vector store; sampled with start.
REQ-008 SHALL have port abort  input  1  pipeline flush; cancels the op in flight.
REQ-009 SHALL have port base_addr  input  AW  address of lane 0.
REQ-010 SHALL have port stride  input  AW  address increment between lanes.
REQ-011 SHALL have port vec_wdata  input  LANES*DW  store source vector; lane k = bits [k*DW +: DW].
REQ-012 SHALL have port mem_rdata  input  DW  memory read data, valid exactly one cycle after mem_re.
REQ-013 SHALL have port mem_addr  output  AW  memory address.
REQ-014 SHALL have port mem_re  output  1  memory read strobe.
REQ-015 SHALL have port mem_we  output  1  memory write strobe.
REQ-016 SHALL have port mem_wdata  output  DW  memory write data.
REQ-017 SHALL have port vec_rdata  output  LANES*DW  assembled load vector.
REQ-018 SHALL have port vreg_we  output  1  one-cycle vector register file write enable.
REQ-019 SHALL have port stall  output  1  holds the pipeline front end.
REQ-020 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-021 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-022 SHALL implement states IDLE, RUN, DRAIN, FIN.
REQ-023 SHALL accept start only in IDLE or FIN; on acceptance it SHALL latch load, base_addr, stride and vec_wdata, clear the lane counter, and enter RUN; start in RUN or DRAIN SHALL be ignored.
REQ-024 In RUN with lane counter k, the block SHALL drive mem_addr = base + k*stride mod 2^AW and mem_wdata = latched lane k; mem_re SHALL equal load and mem_we SHALL equal not load.
REQ-025 SHALL issue exactly one lane per RUN cycle, in order 0..LANES-1, for LANES consecutive RUN cycles.
REQ-026 After lane LANES-1, a store SHALL go to FIN and a load SHALL go to DRAIN for one cycle, then to FIN.
REQ-027 For a load, mem_rdata SHALL be written into vec_rdata lane k on the edge ending the cycle after lane k's issue; the last lane is captured on the edge ending DRAIN.
REQ-028 Unwritten vec_rdata lanes SHALL hold their value.
REQ-029 FIN SHALL last one cycle with done=1 and vreg_we=load; from FIN the block SHALL go to RUN if start is accepted, else to IDLE.
REQ-030 Latency from the start-accepting edge to done: store LANES+1 cycles, load LANES+2 cycles.
REQ-031 stall SHALL be 1 in RUN and DRAIN, and in IDLE or FIN when start=1 and abort=0; otherwise 0.
REQ-032 mem_re, mem_we, vreg_we and done SHALL be 0 in IDLE and whenever abort=1.
REQ-033 abort=1 SHALL force the next state to IDLE from any state, with no done and no vreg_we.
REQ-034 A start in the same cycle as abort SHALL be ignored.
REQ-035 An abort during a load SHALL leave the vec_rdata lanes already captured unchanged.
REQ-036 The lane counter SHALL be $clog2(LANES) bits and SHALL not wrap within an op.

Reset
REQ-037 rst=0 SHALL immediately force state IDLE and the lane counter to 0.
REQ-038 rst=0 SHALL immediately set vec_rdata, mem_addr and mem_wdata to 0, and set mem_re, mem_we, vreg_we, stall, busy and done to 0, including mid-operation.
REQ-039 After rst deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-040 Store: LANES=4, base=0x100, stride=4, vec_wdata=0x44332211, load=0 -> mem_we on 4 cycles; addr/data pairs 0x100/11, 0x104/22, 0x108/33, 0x10C/44; done at cycle 5; vreg_we never asserted.
REQ-041 Load: base=0x200, stride=1, memory returns AA,BB,CC,DD -> mem_re at 0x200..0x203; DRAIN; FIN with vreg_we=done=1 and vec_rdata=0xDDCCBBAA at cycle 6.
REQ-042 Wrap: base=0xFFFFFFFC, stride=4 -> addresses 0xFFFFFFFC, 0x0, 0x4, 0x8.
REQ-043 Abort after lane 1 of a load -> IDLE next cycle; no done or vreg_we; lanes 0 and 1 of vec_rdata hold the captured data; stall drops.
REQ-044 Back-to-back: start held high through the FIN of a store -> next op enters RUN directly; start pulses during RUN are ignored (exactly 4 issues per op).
REQ-045 Async reset asserted mid-RUN, between clock edges -> all outputs 0 immediately; after release, a new load completes normally.
